fifo_fwft_prog: RTL and testbench



---
 rtl/fifo_fwft_prog_if.sv | 22 ++
 rtl/fifo_fwft_prog.sv | 143 ++++++++++++++
 tb/tb_fifo_fwft_prog.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/fifo_fwft_prog_if.sv
// Stream handshake bundle for fifo_fwft_prog: write side and read side of the queue.
// The master modport belongs to whoever produces writes and consumes reads.
interface fifo_fwft_prog_if #(
  parameter int DATA_WIDTH = 64
);
  logic                  s_write_req;
  logic [DATA_WIDTH-1:0] s_write_data;
  logic                  s_write_ready;
  logic                  s_read_req;
  logic [DATA_WIDTH-1:0] s_read_data;
  logic                  s_read_ready;

  modport master (
    output s_write_req, s_write_data, s_read_req,
    input  s_write_ready, s_read_data, s_read_ready
  );

  modport slave (
    input  s_write_req, s_write_data, s_read_req,
    output s_write_ready, s_read_data, s_read_ready
  );
endinterface

// File: rtl/fifo_fwft_prog.sv
// Synchronous FIFO with selectable first-word-fall-through or registered read,
// programmable almost-full/almost-empty flags, occupancy count, flush and sticky error flags.
module fifo_fwft_prog #(
  parameter int    DATA_WIDTH = 64,
  parameter int    ADDR_WIDTH = 4,
  parameter int    RAM_DEPTH  = 1 << ADDR_WIDTH,
  parameter int    FWFT       = 1,
  parameter int    AF_THRESH  = RAM_DEPTH - 4,
  parameter int    AE_THRESH  = 4,
  parameter string TYPE       = "distributed"
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush_i,
  input  logic                  clear_err_i,
  fifo_fwft_prog_if.slave       bus,
  output logic [ADDR_WIDTH:0]   count_o,
  output logic                  almost_full_o,
  output logic                  almost_empty_o,
  output logic                  overflow_o,
  output logic                  underflow_o
);

  localparam int CW = ADDR_WIDTH + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(RAM_DEPTH);
  localparam logic [CW-1:0] AF_C    = CW'(AF_THRESH);
  localparam logic [CW-1:0] AE_C    = CW'(AE_THRESH);

  if (RAM_DEPTH != (1 << ADDR_WIDTH) || RAM_DEPTH < 4 || TYPE == "") begin : g_bad_params
    $error("fifo_fwft_prog: RAM_DEPTH must equal 1<<ADDR_WIDTH and be at least 4");
  end

  (* ram_style = TYPE *) logic [DATA_WIDTH-1:0] mem_q [RAM_DEPTH];

  logic [ADDR_WIDTH-1:0] wrPtr_q, wrPtr_d;
  logic [ADDR_WIDTH-1:0] rdPtr_q, rdPtr_d;
  logic [CW-1:0]         count_q, count_d;
  logic [DATA_WIDTH-1:0] rdData_q, rdData_d;
  logic                  valid_q, valid_d;
  logic                  af_q, af_d;
  logic                  ae_q, ae_d;
  logic                  ovf_q, ovf_d;
  logic                  udf_q, udf_d;

  logic          writeReady;
  logic          readReady;
  logic          pop;
  logic          writeAccept;
  logic          advance;
  logic [CW-1:0] ramWords;

  // In FWFT mode readiness means the output register holds the head word;
  // a write at full is still taken when the same edge pops a word.
  assign writeReady  = (count_q < DEPTH_C);
  assign readReady   = (FWFT != 0) ? valid_q : (count_q != '0);
  assign pop         = bus.s_read_req && readReady && !flush_i;
  assign writeAccept = bus.s_write_req && (writeReady || pop) && !flush_i;
  assign ramWords    = count_q - CW'(valid_q);

  always_comb begin
    wrPtr_d  = wrPtr_q;
    rdPtr_d  = rdPtr_q;
    rdData_d = rdData_q;
    valid_d  = valid_q;
    advance  = 1'b0;

    if (FWFT != 0) begin
      if ((ramWords != '0) && (!valid_q || pop)) begin
        advance = 1'b1;
        valid_d = 1'b1;
      end else if (pop) begin
        valid_d = 1'b0;
      end
    end else begin
      advance = pop;
    end

    if (advance && !flush_i) begin
      rdData_d = mem_q[rdPtr_q];
      rdPtr_d  = rdPtr_q + ADDR_WIDTH'(1);
    end
    if (writeAccept) begin
      wrPtr_d = wrPtr_q + ADDR_WIDTH'(1);
    end
    count_d = count_q + CW'(writeAccept) - CW'(pop);

    ovf_d = (ovf_q && !clear_err_i) || (bus.s_write_req && !writeAccept && !flush_i);
    udf_d = (udf_q && !clear_err_i) || (bus.s_read_req && !readReady && !flush_i);

    // Flush empties the queue but leaves the last presented word and the error history.
    if (flush_i) begin
      wrPtr_d  = '0;
      rdPtr_d  = '0;
      count_d  = '0;
      valid_d  = 1'b0;
      rdData_d = rdData_q;
    end

    af_d = (count_d >= AF_C);
    ae_d = (count_d <= AE_C);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wrPtr_q  <= '0;
      rdPtr_q  <= '0;
      count_q  <= '0;
      rdData_q <= '0;
      valid_q  <= 1'b0;
      af_q     <= 1'b0;
      ae_q     <= 1'b1;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      wrPtr_q  <= wrPtr_d;
      rdPtr_q  <= rdPtr_d;
      count_q  <= count_d;
      rdData_q <= rdData_d;
      valid_q  <= valid_d;
      af_q     <= af_d;
      ae_q     <= ae_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
    end
  end

  // Storage is never cleared; stale words are unreachable once the pointers reset.
  always_ff @(posedge clk) begin
    if (writeAccept) begin
      mem_q[wrPtr_q] <= bus.s_write_data;
    end
  end

  assign bus.s_write_ready = writeReady;
  assign bus.s_read_ready  = readReady;
  assign bus.s_read_data   = rdData_q;
  assign count_o           = count_q;
  assign almost_full_o     = af_q;
  assign almost_empty_o    = ae_q;
  assign overflow_o        = ovf_q;
  assign underflow_o       = udf_q;

endmodule

// File: tb/tb_fifo_fwft_prog.sv
// Directed bench for fifo_fwft_prog: one FWFT instance and one standard-mode instance,
// driven from a vector table plus hand-written multi-cycle sequences.
module tb_fifo_fwft_prog;

  typedef struct packed {
    logic       wready;
    logic       rready;
    logic [7:0] rdata;
    logic [4:0] count;
    logic       af;
    logic       ae;
    logic       ovf;
    logic       udf;
  } out_t;

  typedef struct packed {
    logic       wr;
    logic [7:0] wdata;
    logic       rd;
    logic       fl;
    logic       clr;
    out_t       exp;
  } vec_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic flush = 1'b0;
  logic clearErr = 1'b0;

  logic [4:0] countF, countS;
  logic afF, aeF, ovfF, udfF;
  logic afS, aeS, ovfS, udfS;

  int vecCount = 0;
  int missCount = 0;
  vec_t vecs[14];

  fifo_fwft_prog_if #(.DATA_WIDTH(8)) busF ();
  fifo_fwft_prog_if #(.DATA_WIDTH(8)) busS ();

  fifo_fwft_prog #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .FWFT(1)) dutF (
    .clk(clk), .reset(reset), .flush_i(flush), .clear_err_i(clearErr), .bus(busF),
    .count_o(countF), .almost_full_o(afF), .almost_empty_o(aeF),
    .overflow_o(ovfF), .underflow_o(udfF)
  );

  fifo_fwft_prog #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .FWFT(0)) dutS (
    .clk(clk), .reset(reset), .flush_i(flush), .clear_err_i(clearErr), .bus(busS),
    .count_o(countS), .almost_full_o(afS), .almost_empty_o(aeS),
    .overflow_o(ovfS), .underflow_o(udfS)
  );

  always #5 clk = ~clk;

  function automatic out_t mkOut(logic wready, logic rready, logic [7:0] rdata,
                                 logic [4:0] count, logic af, logic ae, logic ovf, logic udf);
    out_t o;
    o = {wready, rready, rdata, count, af, ae, ovf, udf};
    return o;
  endfunction

  function automatic vec_t mkVec(logic wr, logic [7:0] wdata, logic rd, logic fl, logic clr, out_t e);
    vec_t v;
    v = {wr, wdata, rd, fl, clr, e};
    return v;
  endfunction

  // Inputs change on the falling edge; outputs are sampled 1 time unit after the rising edge.
  task automatic applyStimulus(input bit sel, input logic wr, input logic [7:0] wdata,
                               input logic rd, input logic fl, input logic clr);
    @(negedge clk);
    if (sel) begin
      busS.s_write_req = wr; busS.s_write_data = wdata; busS.s_read_req = rd;
    end else begin
      busF.s_write_req = wr; busF.s_write_data = wdata; busF.s_read_req = rd;
    end
    flush = fl;
    clearErr = clr;
    @(posedge clk);
    #1;
    busF.s_write_req = 1'b0; busF.s_read_req = 1'b0;
    busS.s_write_req = 1'b0; busS.s_read_req = 1'b0;
    flush = 1'b0;
    clearErr = 1'b0;
  endtask

  task automatic checkOutput(input bit sel, input string name, input out_t exp);
    out_t act;
    if (sel)
      act = {busS.s_write_ready, busS.s_read_ready, busS.s_read_data, countS, afS, aeS, ovfS, udfS};
    else
      act = {busF.s_write_ready, busF.s_read_ready, busF.s_read_data, countF, afF, aeF, ovfF, udfF};
    vecCount++;
    if (act !== exp) begin
      missCount++;
      $display("[TB] FAIL %s: got wrdy=%0b rrdy=%0b data=%02h cnt=%0d af=%0b ae=%0b ovf=%0b udf=%0b, expected wrdy=%0b rrdy=%0b data=%02h cnt=%0d af=%0b ae=%0b ovf=%0b udf=%0b",
               name, act.wready, act.rready, act.rdata, act.count, act.af, act.ae, act.ovf, act.udf,
               exp.wready, exp.rready, exp.rdata, exp.count, exp.af, exp.ae, exp.ovf, exp.udf);
    end
  endtask

  task automatic applyReset();
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    logic [7:0] expData;
    logic [4:0] expCnt;

    busF.s_write_req = 1'b0; busF.s_write_data = '0; busF.s_read_req = 1'b0;
    busS.s_write_req = 1'b0; busS.s_write_data = '0; busS.s_read_req = 1'b0;

    // FWFT basic traffic, underflow and clear/error collision.
    vecs[0]  = mkVec(1, 8'h11, 0, 0, 0, mkOut(1, 0, 8'h00, 1, 0, 1, 0, 0));
    vecs[1]  = mkVec(1, 8'h22, 0, 0, 0, mkOut(1, 1, 8'h11, 2, 0, 1, 0, 0));
    vecs[2]  = mkVec(1, 8'h33, 0, 0, 0, mkOut(1, 1, 8'h11, 3, 0, 1, 0, 0));
    vecs[3]  = mkVec(0, 8'h00, 0, 0, 0, mkOut(1, 1, 8'h11, 3, 0, 1, 0, 0));
    vecs[4]  = mkVec(0, 8'h00, 1, 0, 0, mkOut(1, 1, 8'h22, 2, 0, 1, 0, 0));
    vecs[5]  = mkVec(0, 8'h00, 1, 0, 0, mkOut(1, 1, 8'h33, 1, 0, 1, 0, 0));
    vecs[6]  = mkVec(0, 8'h00, 1, 0, 0, mkOut(1, 0, 8'h33, 0, 0, 1, 0, 0));
    vecs[7]  = mkVec(0, 8'h00, 1, 0, 0, mkOut(1, 0, 8'h33, 0, 0, 1, 0, 1));
    vecs[8]  = mkVec(0, 8'h00, 0, 0, 1, mkOut(1, 0, 8'h33, 0, 0, 1, 0, 0));
    vecs[9]  = mkVec(1, 8'h44, 1, 0, 1, mkOut(1, 0, 8'h33, 1, 0, 1, 0, 1));
    vecs[10] = mkVec(0, 8'h00, 0, 0, 1, mkOut(1, 1, 8'h44, 1, 0, 1, 0, 0));
    vecs[11] = mkVec(1, 8'h55, 1, 0, 0, mkOut(1, 0, 8'h44, 1, 0, 1, 0, 0));
    vecs[12] = mkVec(0, 8'h00, 0, 0, 0, mkOut(1, 1, 8'h55, 1, 0, 1, 0, 0));
    vecs[13] = mkVec(0, 8'h00, 1, 0, 0, mkOut(1, 0, 8'h55, 0, 0, 1, 0, 0));

    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    checkOutput(0, "resetF", mkOut(1, 0, 8'h00, 0, 0, 1, 0, 0));
    checkOutput(1, "resetS", mkOut(1, 0, 8'h00, 0, 0, 1, 0, 0));

    for (int i = 0; i < 14; i++) begin
      applyStimulus(0, vecs[i].wr, vecs[i].wdata, vecs[i].rd, vecs[i].fl, vecs[i].clr);
      checkOutput(0, $sformatf("tableF[%0d]", i), vecs[i].exp);
    end

    // Standard read mode: data appears one edge after the pop.
    applyStimulus(1, 1, 8'h5A, 0, 0, 0); checkOutput(1, "stdWr5A", mkOut(1, 1, 8'h00, 1, 0, 1, 0, 0));
    applyStimulus(1, 0, 8'h00, 1, 0, 0); checkOutput(1, "stdPop5A", mkOut(1, 0, 8'h5A, 0, 0, 1, 0, 0));
    applyStimulus(1, 0, 8'h00, 1, 0, 0); checkOutput(1, "stdUnderflow", mkOut(1, 0, 8'h5A, 0, 0, 1, 0, 1));
    applyStimulus(1, 0, 8'h00, 0, 0, 1); checkOutput(1, "stdClr", mkOut(1, 0, 8'h5A, 0, 0, 1, 0, 0));
    applyStimulus(1, 1, 8'hA1, 0, 0, 0); checkOutput(1, "stdWrA1", mkOut(1, 1, 8'h5A, 1, 0, 1, 0, 0));
    applyStimulus(1, 1, 8'hA2, 0, 0, 0); checkOutput(1, "stdWrA2", mkOut(1, 1, 8'h5A, 2, 0, 1, 0, 0));
    applyStimulus(1, 0, 8'h00, 1, 0, 0); checkOutput(1, "stdPopA1", mkOut(1, 1, 8'hA1, 1, 0, 1, 0, 0));
    applyStimulus(1, 1, 8'hA3, 1, 0, 0); checkOutput(1, "stdWrPopA2", mkOut(1, 1, 8'hA2, 1, 0, 1, 0, 0));
    applyStimulus(1, 0, 8'h00, 1, 0, 0); checkOutput(1, "stdPopA3", mkOut(1, 0, 8'hA3, 0, 0, 1, 0, 0));

    // Fill to full, overflow, then write+pop at full and drain.
    applyReset();
    for (int k = 1; k <= 16; k++) begin
      expCnt = 5'(k);
      applyStimulus(0, 1, 8'(k), 0, 0, 0);
      checkOutput(0, $sformatf("fill%0d", k),
                  mkOut(k < 16, k >= 2, (k >= 2) ? 8'h01 : 8'h00, expCnt, k >= 12, k <= 4, 0, 0));
    end
    applyStimulus(0, 1, 8'hEE, 0, 0, 0); checkOutput(0, "overflow", mkOut(0, 1, 8'h01, 16, 1, 0, 1, 0));
    applyStimulus(0, 0, 8'h00, 0, 0, 1); checkOutput(0, "clrOverflow", mkOut(0, 1, 8'h01, 16, 1, 0, 0, 0));
    applyStimulus(0, 1, 8'hAA, 1, 0, 0); checkOutput(0, "fullWrPop", mkOut(0, 1, 8'h02, 16, 1, 0, 0, 0));
    for (int j = 0; j < 16; j++) begin
      expCnt = 5'(15 - j);
      if (j <= 13) expData = 8'(j + 3);
      else expData = 8'hAA;
      applyStimulus(0, 0, 8'h00, 1, 0, 0);
      checkOutput(0, $sformatf("drain%0d", j),
                  mkOut(1, j < 15, expData, expCnt, (15 - j) >= 12, (15 - j) <= 4, 0, 0));
    end

    // Steady write+pop stream long enough to wrap both pointers.
    applyStimulus(0, 1, 8'hC0, 0, 0, 0); checkOutput(0, "wrapPre0", mkOut(1, 0, 8'hAA, 1, 0, 1, 0, 0));
    applyStimulus(0, 1, 8'hC1, 0, 0, 0); checkOutput(0, "wrapPre1", mkOut(1, 1, 8'hC0, 2, 0, 1, 0, 0));
    applyStimulus(0, 1, 8'hC2, 0, 0, 0); checkOutput(0, "wrapPre2", mkOut(1, 1, 8'hC0, 3, 0, 1, 0, 0));
    for (int k = 0; k < 40; k++) begin
      applyStimulus(0, 1, 8'(8'hC3 + k), 1, 0, 0);
      checkOutput(0, $sformatf("wrap%0d", k), mkOut(1, 1, 8'(8'hC1 + k), 3, 0, 1, 0, 0));
    end

    // Flush with concurrent requests.
    applyReset();
    for (int i = 0; i < 10; i++) applyStimulus(0, 1, 8'(8'h30 + i), 0, 0, 0);
    checkOutput(0, "load10", mkOut(1, 1, 8'h30, 10, 0, 0, 0, 0));
    applyStimulus(0, 1, 8'h99, 1, 1, 0); checkOutput(0, "flushWrRd", mkOut(1, 0, 8'h30, 0, 0, 1, 0, 0));
    applyStimulus(0, 0, 8'h00, 1, 1, 0); checkOutput(0, "flushEmptyRd", mkOut(1, 0, 8'h30, 0, 0, 1, 0, 0));
    applyStimulus(0, 1, 8'h77, 0, 0, 0); checkOutput(0, "postFlushWr", mkOut(1, 0, 8'h30, 1, 0, 1, 0, 0));
    applyStimulus(0, 0, 8'h00, 0, 0, 0); checkOutput(0, "postFlushHead", mkOut(1, 1, 8'h77, 1, 0, 1, 0, 0));
    applyStimulus(0, 0, 8'h00, 1, 0, 0); checkOutput(0, "postFlushPop", mkOut(1, 0, 8'h77, 0, 0, 1, 0, 0));

    // Reset in the middle of traffic with a sticky flag set.
    applyStimulus(0, 0, 8'h00, 1, 0, 0); checkOutput(0, "preResetUdf", mkOut(1, 0, 8'h77, 0, 0, 1, 0, 1));
    for (int i = 0; i < 7; i++) applyStimulus(0, 1, 8'(8'h60 + i), 0, 0, 0);
    checkOutput(0, "load7", mkOut(1, 1, 8'h60, 7, 0, 0, 0, 1));
    @(negedge clk);
    reset = 1'b1;
    busF.s_write_req = 1'b1; busF.s_write_data = 8'hFF; busF.s_read_req = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    busF.s_write_req = 1'b0; busF.s_read_req = 1'b0;
    checkOutput(0, "midReset", mkOut(1, 0, 8'h00, 0, 0, 1, 0, 0));
    applyStimulus(0, 1, 8'h81, 0, 0, 0); checkOutput(0, "afterResetWr", mkOut(1, 0, 8'h00, 1, 0, 1, 0, 0));
    applyStimulus(0, 0, 8'h00, 0, 0, 0); checkOutput(0, "afterResetHead", mkOut(1, 1, 8'h81, 1, 0, 1, 0, 0));
    applyStimulus(0, 0, 8'h00, 1, 0, 0); checkOutput(0, "afterResetPop", mkOut(1, 0, 8'h81, 0, 0, 1, 0, 0));

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
